// File: rtl/ram_delay_pkg.sv
// Shared constants and the delay clamp used by the programmable RAM delay line.
package ram_delay_pkg;

    localparam int MIN_DELAY    = 3;
    localparam int RAM_PIPE_LAT = 2;

    // The floor of 3 keeps the write address away from the registered read address.
    function automatic logic [31:0] clamp_delay(input logic [31:0] value, input logic [31:0] max_delay);
        logic [31:0] result;
        if (value < 32'(MIN_DELAY)) begin
            result = 32'(MIN_DELAY);
        end else if (value > max_delay) begin
            result = max_delay;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/sdp_ram_2reg.sv
// Simple dual-port inferred RAM with a registered read address and a registered output,
// both advancing on a shared clock enable.
module sdp_ram_2reg #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0]      mem_r [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic [WIDTH-1:0]      rd_data_r;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read pipeline: address register then output register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rd_addr_r <= '0;
            rd_data_r <= '0;
        end else if (ce) begin
            rd_addr_r <= rd_addr;
            rd_data_r <= mem_r[rd_addr_r];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/ram_delay_line_prog.sv
// Multi-lane RAM delay line with a run-time programmable delay and output-valid tracking.
module ram_delay_line_prog
    import ram_delay_pkg::*;
#(
    parameter int NUM_CHAN      = 4,
    parameter int WIDTH         = 16,
    parameter int ADDR_WIDTH    = 5,
    parameter int MAX_DELAY     = 24,
    parameter int DEFAULT_DELAY = 7,
    parameter bit ZERO_INVALID  = 1'b1
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [ADDR_WIDTH-1:0]       delay_in,
    input  logic                        delay_load,
    input  logic [NUM_CHAN*WIDTH-1:0]   data_in,
    output logic [NUM_CHAN*WIDTH-1:0]   data_out,
    output logic                        out_valid,
    output logic [ADDR_WIDTH-1:0]       delay_cur
);

    localparam int DW = NUM_CHAN * WIDTH;

    logic [ADDR_WIDTH-1:0] pointer_r;
    logic [ADDR_WIDTH-1:0] delay_r;
    logic [ADDR_WIDTH-1:0] fill_r;
    logic                  valid_r;
    logic [ADDR_WIDTH-1:0] delay_ld_s;
    logic [ADDR_WIDTH-1:0] delay_eff_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [ADDR_WIDTH-1:0] fill_inc_s;
    logic [DW-1:0]         ram_q_s;
    logic                  ram_we_s;

    assign delay_ld_s = ADDR_WIDTH'(clamp_delay(32'(delay_in), 32'(MAX_DELAY)));

    // A sample written on the load cycle already belongs to the new delay, so the
    // write address uses the incoming clamped value on that cycle only.
    always_comb begin
        delay_eff_s = delay_r;
        if (delay_load) begin
            delay_eff_s = delay_ld_s;
        end else begin
            delay_eff_s = delay_r;
        end
    end

    assign wr_addr_s = pointer_r + delay_eff_s - ADDR_WIDTH'(RAM_PIPE_LAT);
    assign ram_we_s  = enable & rst_n;

    // Saturating fill increment.
    always_comb begin
        fill_inc_s = fill_r;
        if (fill_r < delay_r) begin
            fill_inc_s = fill_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            fill_inc_s = fill_r;
        end
    end

    // Pointer, delay, fill and valid state.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            pointer_r <= '0;
            delay_r   <= ADDR_WIDTH'(DEFAULT_DELAY);
            fill_r    <= '0;
            valid_r   <= 1'b0;
        end else begin
            if (enable) begin
                pointer_r <= pointer_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (delay_load) begin
                delay_r <= delay_ld_s;
                fill_r  <= enable ? {{(ADDR_WIDTH-1){1'b0}}, 1'b1} : '0;
                valid_r <= 1'b0;
            end else if (enable) begin
                fill_r  <= fill_inc_s;
                valid_r <= (fill_inc_s == delay_r);
            end
        end
    end

    sdp_ram_2reg #(
        .WIDTH      (DW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .rst_n   (rst_n),
        .ce      (enable),
        .we      (ram_we_s),
        .wr_addr (wr_addr_s),
        .wr_data (data_in),
        .rd_addr (pointer_r),
        .rd_data (ram_q_s)
    );

    assign data_out  = (ZERO_INVALID && !valid_r) ? '0 : ram_q_s;
    assign out_valid = valid_r;
    assign delay_cur = delay_r;

endmodule

// File: tb/tb_ram_delay_line_prog.sv
// Self-checking bench: directed phases plus random traffic against a sample-history model.
module tb_ram_delay_line_prog;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [4:0]  delay_in;
    logic        delay_load;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic        out_valid;
    logic [4:0]  delay_cur;

    int total = 0;
    int bad   = 0;

    logic [63:0] hist[$];
    int          cnt;
    int          exp_delay;
    logic        exp_valid;
    logic [63:0] exp_data;

    always #5 clock = ~clock;

    ram_delay_line_prog dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .enable     (enable),
        .delay_in   (delay_in),
        .delay_load (delay_load),
        .data_in    (data_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .delay_cur  (delay_cur)
    );

    function automatic int clamp(input int v);
        if (v < 3) return 3;
        if (v > 24) return 24;
        return v;
    endfunction

    task automatic check_all(input string tag);
        total++;
        assert (out_valid === exp_valid) else begin
            bad++;
            $error("FAIL %s out_valid got %b exp %b", tag, out_valid, exp_valid);
        end
        total++;
        assert (data_out === exp_data) else begin
            bad++;
            $error("FAIL %s data_out got %h exp %h", tag, data_out, exp_data);
        end
        total++;
        assert (delay_cur === 5'(exp_delay)) else begin
            bad++;
            $error("FAIL %s delay_cur got %0d exp %0d", tag, delay_cur, exp_delay);
        end
    endtask

    // Drive one cycle at the falling edge, advance the model at the rising edge, check after.
    task automatic step(input logic rs, input logic en, input logic ld, input int din,
                        input logic [63:0] d, input string tag);
        rst_n      = rs;
        enable     = en;
        delay_load = ld;
        delay_in   = 5'(din);
        data_in    = d;
        @(posedge clock);
        if (!rs) begin
            cnt = 0; exp_delay = 7; exp_valid = 1'b0; exp_data = '0;
        end else if (ld) begin
            exp_delay = clamp(din);
            cnt = en ? 1 : 0;
            if (en) hist.push_back(d);
            exp_valid = 1'b0;
            exp_data  = '0;
        end else if (en) begin
            hist.push_back(d);
            if (cnt < exp_delay) cnt++;
            exp_valid = (cnt >= exp_delay);
            exp_data  = exp_valid ? hist[hist.size() - exp_delay] : 64'd0;
        end
        @(negedge clock);
        check_all(tag);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst_n = 1'b0; enable = 1'b0; delay_load = 1'b0; delay_in = 5'd0; data_in = 64'd0;
        cnt = 0; exp_delay = 7; exp_valid = 1'b0; exp_data = '0;
        @(negedge clock);

        step(1'b0, 1'b1, 1'b0, 0, rnd64(), "reset0");
        step(1'b0, 1'b0, 1'b0, 0, rnd64(), "reset1");

        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 0, {rnd64() >> 16, 16'(i)}, "ramp");
            if (i == 7) begin
                total++;
                assert (out_valid === 1'b1 && data_out[15:0] === 16'd1) else begin
                    bad++;
                    $error("FAIL ramp_first got v=%b lane0=%0d exp v=1 lane0=1", out_valid, data_out[15:0]);
                end
            end
        end

        for (int i = 0; i < 24; i++)
            step(1'b1, 1'((i % 2) == 0), 1'b0, 0, {rnd64() >> 16, 16'(100 + i)}, "gate");

        step(1'b1, 1'b1, 1'b1, 20, rnd64(), "retune_load");
        for (int i = 0; i < 24; i++)
            step(1'b1, 1'b1, 1'b0, 0, rnd64(), "retune_fill");

        step(1'b1, 1'b1, 1'b1, 1, rnd64(), "clamp_lo");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 0, rnd64(), "clamp_lo_fill");
        step(1'b1, 1'b0, 1'b1, 31, rnd64(), "clamp_hi");
        step(1'b1, 1'b1, 1'b1, 24, rnd64(), "flush_same");

        for (int i = 0; i < 100; i++)
            step(1'b1, 1'b1, 1'b0, 0, rnd64(), "wrap");

        step(1'b1, 1'b1, 1'b1, 12, rnd64(), "pre_reset_load");
        for (int i = 0; i < 14; i++)
            step(1'b1, 1'b1, 1'b0, 0, rnd64(), "pre_reset_fill");
        step(1'b0, 1'b1, 1'b1, 20, rnd64(), "reset_mid");
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 1'b0, 0, rnd64(), "refill");

        for (int i = 0; i < 300; i++) begin
            logic ld;
            ld = ($urandom_range(0, 19) == 0);
            step(1'b1, 1'($urandom_range(0, 3) != 0), ld, int'($urandom_range(0, 31)), rnd64(), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_delay_line_prog.md
Name: ram_delay_line_prog

Overview:
- Multi-channel RAM-based delay line whose delay is programmable at run time. It is the successor to the fixed-depth RAM delay register.
- All channels share one enable and one delay. Output-valid tracking suppresses stale RAM contents after reset or after a delay change.
- Sits in datapath pipelines that need long, retunable skew-matching delays without burning logic registers.
- RAM is inferred behaviourally, not vendor-instantiated, so the block stays portable.

Parameters:
- NUM_CHAN, 4, number of independent data lanes packed into the data bus.
- WIDTH, 16, bits per lane.
- ADDR_WIDTH, 5, RAM address bits; 2^ADDR_WIDTH > MAX_DELAY required.
- MAX_DELAY, 24, largest legal delay in enabled cycles.
- DEFAULT_DELAY, 7, delay in force after reset; must be within 3..MAX_DELAY.
- ZERO_INVALID, 1, when 1 data_out is forced to 0 while out_valid=0.

Ports:
- clock, in, 1, the single clock; all logic is rising-edge.
- rst_n, in, 1, reset; synchronous, active-low.
- enable, in, 1, clock enable; pointer, RAM write, RAM read pipeline and fill counter advance only when high.
- delay_in, in, ADDR_WIDTH, requested delay value.
- delay_load, in, 1, one-cycle strobe; captures delay_in.
- data_in, in, NUM_CHAN*WIDTH, lane k occupies bits [k*WIDTH +: WIDTH].
- data_out, out, NUM_CHAN*WIDTH, delayed data.
- out_valid, out, 1, data_out holds a sample actually written under the current delay.
- delay_cur, out, ADDR_WIDTH, delay currently in force (post-clamp).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge) sets:
  - pointer=0, fill=0, out_valid=0, data_out=0, delay_cur=DEFAULT_DELAY.
  - RAM contents are not cleared.
- Reset overrides delay_load and enable in the same cycle.
- Delay clamp, applied on delay_load:
  - delay_in<3 gives 3.
  - delay_in>MAX_DELAY gives MAX_DELAY.
  - Minimum is 3 so the write and read addresses never coincide; mixed-port read-during-write is never exercised.
- Addressing (all mod 2^ADDR_WIDTH):
  - rd_addr=pointer.
  - wr_addr=pointer+(delay_cur-2).
  - The 2 accounts for the RAM address register plus the output register.
  - pointer increments on each enabled cycle and wraps naturally.
- Latency:
  - Sample written on enabled edge n appears on data_out after enabled edge n+delay_cur-1, i.e. exactly delay_cur enabled cycles of delay.
  - Disabled cycles freeze every register, including RAM read address and output registers, so data_out holds.
- Write: on every enabled cycle, all lanes are written in one word. No per-lane masking.
- Fill counter:
  - Saturating, 0..delay_cur.
  - Increments on each enabled cycle.
  - out_valid=1 when fill==delay_cur, registered so it rises on the same edge as the first valid data_out.
- delay_load (rst_n=1):
  - delay_cur takes the clamped value at that edge.
  - fill restarts: set to 1 if enable is also high that cycle (the sample written that cycle counts under the new delay), else 0.
  - out_valid falls on that same edge.
  - pointer is not reset; it advances if enable is high.
- delay_load while enable=0: delay_cur still updates and fill still clears.
- delay_load with an unchanged value: still restarts fill. Intentional, so software can flush.
- ZERO_INVALID=1: data_out=0 whenever out_valid=0. ZERO_INVALID=0: raw RAM output is passed through.
- delay_cur is held stable between loads. Implementation must not glitch wr_addr mid-cycle.

Decomposition:
- Package ram_delay_pkg holds:
  - MIN_DELAY=3.
  - RAM_PIPE_LAT=2.
  - A function clamp_delay(value, max) returning the legal delay.
- Sub-module sdp_ram_2reg:
  - Simple dual-port inferred RAM with one write port and one read port.
  - Read address register and output register, both gated by a shared clock enable.
  - Parameters WIDTH and ADDR_WIDTH.
- Top holds pointer, delay register, fill counter, valid and zeroing logic.

Test Plan:
- Reset then steady ramp: after reset, enable=1, data_in lane0=counter starting 1 → out_valid rises after 7th enabled edge with lane0=1; thereafter lane0 tracks input minus 7.
- Enable gating: ramp with enable toggling 1,0,1,0 → data_out changes only on enabled edges; delay measured in enabled cycles stays 7; data_out frozen on disabled cycles.
- Retune: while valid at DEFAULT_DELAY, load delay_in=20 with enable=1 → out_valid drops the next edge, data_out=0, re-rises 20 enabled edges later, showing data from the load cycle.
- Clamp: load 1 → delay_cur=3, valid after 3 enables; load 31 → delay_cur=24.
- Pointer wrap: run 100 enabled cycles at delay 24 with ADDR_WIDTH=5 → no sample lost or duplicated across wrap; compare against a reference queue.
- Reset mid-operation: assert rst_n=0 for one cycle while valid, with delay_load=1 and enable=1 the same cycle → delay_cur=7, out_valid=0, data_out=0; refill takes 7 enables.
